// File: rtl/rocc_cmd_arbiter.sv
// rocc_cmd_arbiter: round-robin share of one RoCC cmd/resp port among NUM_REQ requesters
module rocc_cmd_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDX_W = $clog2(NUM_REQ),
  localparam int PTR_W = $clog2(MAX_OUTSTANDING),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*64-1:0]   req_rs1_i,
  input  logic [NUM_REQ*64-1:0]   req_rs2_i,
  input  logic [NUM_REQ*32-1:0]   req_instr_i,
  output logic                    cmd_valid_o,
  input  logic                    cmd_ready_i,
  output logic [63:0]             cmd_rs1_o,
  output logic [63:0]             cmd_rs2_o,
  output logic [31:0]             cmd_instr_o,
  input  logic                    resp_valid_i,
  output logic                    resp_ready_o,
  input  logic [63:0]             resp_data_i,
  output logic [NUM_REQ-1:0]      req_resp_valid_o,
  output logic [63:0]             req_resp_data_o,
  output logic [CNT_W-1:0]        outstanding_o,
  output logic                    orphan_resp_o
);
  logic [IDX_W-1:0] r_rr, r_lock_idx;
  logic             r_lock;
  logic [IDX_W-1:0] r_tags [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic [2*NUM_REQ-1:0] w_rot;
  logic [IDX_W-1:0] w_off, w_rr_win, w_win, w_sel;
  logic [IDX_W:0]   w_sum;
  logic             w_full, w_empty, w_hs, w_pop;
  // rotate valids so bit 0 is the requester at the round-robin pointer
  assign w_rot = {req_valid_i, req_valid_i} >> r_rr;
  always_comb begin
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (w_rot[i]) w_off = IDX_W'(i);
  end
  assign w_sum    = (IDX_W+1)'(r_rr) + (IDX_W+1)'(w_off);
  assign w_rr_win = (w_sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ)) : IDX_W'(w_sum);
  assign w_win    = r_lock ? r_lock_idx : w_rr_win;
  assign w_sel    = rst_i ? '0 : w_win;
  assign w_full   = r_cnt == CNT_W'(MAX_OUTSTANDING);
  assign w_empty  = r_cnt == '0;
  assign cmd_valid_o = |req_valid_i && !w_full && !rst_i;
  assign w_hs        = cmd_valid_o && cmd_ready_i;
  assign req_ready_o = w_hs ? NUM_REQ'(1) << w_win : '0;
  assign cmd_rs1_o   = req_rs1_i[64*w_sel +: 64];
  assign cmd_rs2_o   = req_rs2_i[64*w_sel +: 64];
  assign cmd_instr_o = req_instr_i[32*w_sel +: 32];
  assign resp_ready_o     = !rst_i;
  assign w_pop            = resp_valid_i && !rst_i && !w_empty;
  assign orphan_resp_o    = resp_valid_i && !rst_i && w_empty;
  assign req_resp_valid_o = w_pop ? NUM_REQ'(1) << r_tags[r_rptr] : '0;
  assign req_resp_data_o  = resp_data_i;
  assign outstanding_o    = r_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr <= '0;
      r_lock <= 1'b0;
      r_lock_idx <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt <= '0;
    end else if (flush_i) begin
      r_lock <= 1'b0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt <= '0;
    end else begin
      r_lock <= cmd_valid_o && !cmd_ready_i;
      r_lock_idx <= w_win;
      if (w_hs) r_rr <= (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
      if (w_hs) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + CNT_W'(w_hs) - CNT_W'(w_pop);
    end
  end
  always_ff @(posedge clk_i)
    if (w_hs) r_tags[r_wptr] <= w_win;
endmodule

// File: tb/tb_rocc_cmd_arbiter.sv
// tb_rocc_cmd_arbiter: directed stimulus with a response-ownership scoreboard
module tb_rocc_cmd_arbiter;
  logic         clk = 0, rst = 1, flush = 0;
  logic [1:0]   req_valid = '0, req_ready;
  logic [127:0] req_rs1, req_rs2;
  logic [63:0]  req_instr;
  logic         cmd_valid, cmd_ready = 0;
  logic [63:0]  cmd_rs1, cmd_rs2;
  logic [31:0]  cmd_instr;
  logic         resp_valid = 0, resp_ready;
  logic [63:0]  resp_data = '0;
  logic [1:0]   req_resp_valid;
  logic [63:0]  req_resp_data;
  logic [2:0]   outstanding;
  logic         orphan;
  int n_chk = 0, n_fail = 0;
  logic [1:0] q[$];

  assign req_rs1   = {64'h11, 64'h100};
  assign req_rs2   = {64'h22, 64'h200};
  assign req_instr = {32'h0B, 32'h0A};

  always #5 clk = ~clk;

  rocc_cmd_arbiter #(.NUM_REQ(2), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_instr_i(req_instr),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
    .cmd_rs1_o(cmd_rs1), .cmd_rs2_o(cmd_rs2), .cmd_instr_o(cmd_instr),
    .resp_valid_i(resp_valid), .resp_ready_o(resp_ready), .resp_data_i(resp_data),
    .req_resp_valid_o(req_resp_valid), .req_resp_data_o(req_resp_data),
    .outstanding_o(outstanding), .orphan_resp_o(orphan)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] v, input logic rdy, input logic rv, input logic [63:0] rd,
                      input logic fl, input logic exp_cv, input logic exp_g,
                      input logic [1:0] exp_rdy, input int exp_out);
    logic [1:0] e;
    @(negedge clk);
    req_valid = v; cmd_ready = rdy; resp_valid = rv; resp_data = rd; flush = fl;
    #1;
    check("cmd_valid", cmd_valid, exp_cv);
    check("req_ready", req_ready, exp_rdy);
    check("outstanding", outstanding, exp_out);
    check("resp_ready", resp_ready, 1);
    if (exp_cv) begin
      check("cmd_rs1", cmd_rs1, exp_g ? 64'h11 : 64'h100);
      check("cmd_rs2", cmd_rs2, exp_g ? 64'h22 : 64'h200);
      check("cmd_instr", cmd_instr, exp_g ? 32'h0B : 32'h0A);
    end
    if (rv && q.size() > 0) begin
      e = q.pop_front();
      check("resp_strobe", req_resp_valid, e);
      check("resp_data", req_resp_data, rd);
      check("orphan", orphan, 0);
    end else begin
      check("resp_strobe", req_resp_valid, 0);
      check("orphan", orphan, rv);
    end
    if (exp_rdy != 0) q.push_back(exp_rdy);
    if (fl) q.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 2'b11; cmd_ready = 1; resp_valid = 1; resp_data = 64'h77;
    #1;
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_ready", resp_ready, 0);
    check("rst_resp_strobe", req_resp_valid, 0);
    check("rst_orphan", orphan, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_cmd_rs1", cmd_rs1, 64'h100);
    check("rst_cmd_instr", cmd_instr, 32'h0A);
    check("rst_resp_data", req_resp_data, 64'h77);
    rst = 0; req_valid = '0; cmd_ready = 0; resp_valid = 0;
    // single requester
    step(2'b10, 1, 0, 0, 0, 1, 1, 2'b10, 0);
    step(2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 1);
    step(2'b00, 0, 1, 64'hA0, 0, 0, 0, 2'b00, 1);
    // contention fills the FIFO
    step(2'b11, 1, 0, 0, 0, 1, 0, 2'b01, 0);
    step(2'b11, 1, 0, 0, 0, 1, 1, 2'b10, 1);
    step(2'b11, 1, 0, 0, 0, 1, 0, 2'b01, 2);
    step(2'b11, 1, 0, 0, 0, 1, 1, 2'b10, 3);
    // full, pop does not unblock the same cycle
    step(2'b11, 1, 0, 0, 0, 0, 0, 2'b00, 4);
    step(2'b11, 1, 1, 64'hD1, 0, 0, 0, 2'b00, 4);
    step(2'b11, 1, 0, 0, 0, 1, 0, 2'b01, 3);
    for (int i = 0; i < 4; i++) step(2'b00, 0, 1, 64'hC0 + i, 0, 0, 0, 2'b00, 4 - i);
    // back-pressure lock on requester 0 while pointer favours 1
    step(2'b01, 0, 0, 0, 0, 1, 0, 2'b00, 0);
    step(2'b11, 0, 0, 0, 0, 1, 0, 2'b00, 0);
    step(2'b11, 0, 0, 0, 0, 1, 0, 2'b00, 0);
    step(2'b11, 1, 0, 0, 0, 1, 0, 2'b01, 0);
    step(2'b11, 1, 0, 0, 0, 1, 1, 2'b10, 1);
    step(2'b00, 0, 1, 64'h5, 0, 0, 0, 2'b00, 2);
    step(2'b00, 0, 1, 64'h6, 0, 0, 0, 2'b00, 1);
    // ordering 1,0,1
    step(2'b10, 1, 0, 0, 0, 1, 1, 2'b10, 0);
    step(2'b01, 1, 0, 0, 0, 1, 0, 2'b01, 1);
    step(2'b10, 1, 0, 0, 0, 1, 1, 2'b10, 2);
    step(2'b00, 0, 1, 64'hA, 0, 0, 0, 2'b00, 3);
    step(2'b00, 0, 1, 64'hB, 0, 0, 0, 2'b00, 2);
    step(2'b00, 0, 1, 64'hC, 0, 0, 0, 2'b00, 1);
    // flush and orphan
    step(2'b11, 1, 0, 0, 0, 1, 0, 2'b01, 0);
    step(2'b11, 1, 0, 0, 0, 1, 1, 2'b10, 1);
    step(2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 2);
    step(2'b00, 0, 1, 64'hEE, 0, 0, 0, 2'b00, 0);
    step(2'b01, 1, 0, 0, 1, 1, 0, 2'b01, 0);
    step(2'b11, 1, 0, 0, 0, 1, 0, 2'b01, 0);
    // reset mid-transaction drops the outstanding tag
    @(negedge clk);
    rst = 1; req_valid = '0; cmd_ready = 0; resp_valid = 0; flush = 0;
    @(negedge clk);
    check("midrst_outstanding", outstanding, 0);
    check("midrst_resp_ready", resp_ready, 0);
    rst = 0;
    q.delete();
    step(2'b00, 0, 1, 64'h99, 0, 0, 0, 2'b00, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
